pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage CPU. Combines per-stage stall requests with load-use hazard detection on the decode stage's register reads and produces the per-stage stall vector. Sequences exception flushes through a small state machine that issues the redirect PC. Keeps saturating stall and load-use performance counters. It sits beside the IF/ID/EX/MEM/WB stage registers and drives their hold and clear inputs.

## Interface
- STALL_CNT_W, 32, width of the stall-cycle counter
- LU_CNT_W, 16, width of the load-use event counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stallreq_if  in  1  fetch stage cannot advance
- stallreq_id  in  1  decode stage cannot advance (external cause)
- stallreq_ex  in  1  execute stage busy (multi-cycle op)
- stallreq_mem  in  1  memory stage waiting on bus
- id_reg1_read, id_reg2_read  in  1 each  decode read enables
- id_reg1_addr, id_reg2_addr  in  5 each  decode read addresses (Reg_addr_t)
- ex_mem_read  in  1  instruction in EX is a load
- ex_wreg_write  in  1  EX instruction writes a register
- ex_wreg_addr  in  5  EX destination register
- flush_req  in  1  exception raised in MEM
- flush_target  in  32  handler PC accompanying flush_req
- stall  out  6  hold per stage: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- flush  out  1  clear all stage registers
- new_pc  out  32  redirect PC, valid while flush=1
- stall_cycles  out  STALL_CNT_W  cycles with stall != 0
- loaduse_count  out  LU_CNT_W  load-use bubbles inserted

## Operation
- Load-use hazard (lu): ex_mem_read & ex_wreg_write & (ex_wreg_addr != 0) & ((id_reg1_read & id_reg1_addr == ex_wreg_addr) | (id_reg2_read & id_reg2_addr == ex_wreg_addr)).
- Effective decode request: id_req = stallreq_id | lu.
- Stall vector, highest requesting stage wins:
  - stallreq_mem gives 011111.
  - else stallreq_ex gives 001111.
  - else id_req gives 000111.
  - else stallreq_if gives 000011.
  - else 000000.
  - WB is never stalled.
- FSM states: RUN, FLUSH.
  - RUN: flush=0, and stall follows the rules above. When flush_req=1 and stallreq_mem=0, latch flush_target and go to FLUSH.
  - While stallreq_mem=1, flush_req is not sampled. MEM holds the request stable until its stall releases.
  - FLUSH: one cycle only. flush=1, new_pc = latched target, stall=000000 (all stall requests and lu are masked). flush_req is ignored. Next state is always RUN.
- new_pc is 0 whenever flush=0.
- stall_cycles increments by 1 on each edge where stall != 0, and saturates at all-ones.
- loaduse_count increments on each edge where the hazard causes the stall: lu=1, stallreq_ex=0, stallreq_mem=0, state RUN. It also saturates at all-ones.
- A lu that persists for k cycles (EX frozen by an external id stall) counts k times. This is by design.

## Timing
- stall is combinational from the inputs and the current state: zero latency, same-cycle response.
- flush and new_pc are registered: flush_req sampled at edge N gives flush=1 in the cycle after edge N, for exactly 1 cycle.
- Back-to-back: a flush_req held high through FLUSH is re-sampled in the following RUN cycle. That yields a second flush 2 cycles after the first.
- Reset (synchronous, dominates all inputs): state=RUN, flush=0, new_pc=0, latched target=0, stall_cycles=0, loaduse_count=0.
  - While rst=1, stall is forced to 000000.
  - Reset during FLUSH aborts the flush, so flush=0 in the next cycle.
- Counters update on the same edge that ends the counted cycle. The visible value lags by one cycle.

## Test plan
- Reset: hold rst 2 cycles with all requests high -> stall=000000, flush=0, new_pc=0, both counters 0.
- Load-use: ex_mem_read=1, ex_wreg_write=1, ex_wreg_addr=5, id_reg2_read=1, id_reg2_addr=5 -> stall=000111 same cycle, loaduse_count=1 next cycle. Repeat with ex_wreg_addr=0 or id_reg2_read=0 -> stall=000000, count unchanged.
- Priority: stallreq_if=1 and stallreq_ex=1 together -> 001111. Add stallreq_mem -> 011111. A lu concurrent with stallreq_ex -> 001111 and loaduse_count not incremented.
- Flush: flush_req=1, flush_target=0xBFC00380 for one cycle with stallreq_ex=1 -> next cycle flush=1, new_pc=0xBFC00380, stall=000000. The cycle after: flush=0, new_pc=0.
- Flush blocked by MEM: flush_req=1 with stallreq_mem=1 for 3 cycles, then stallreq_mem=0 -> flush asserted exactly one cycle after the first cycle with stallreq_mem=0.
- Saturation: run with STALL_CNT_W=4 and 20 stalled cycles -> stall_cycles stops at 15. rst during FLUSH -> flush=0 the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage stall requests, decode/EX hazard
// operands, exception flush request and the per-stage hold/clear outputs.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        id_reg1_read;
  logic        id_reg2_read;
  logic [4:0]  id_reg1_addr;
  logic [4:0]  id_reg2_addr;
  logic        ex_mem_read;
  logic        ex_wreg_write;
  logic [4:0]  ex_wreg_addr;
  logic        flush_req;
  logic [31:0] flush_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_if, stallreq_id,
    output stallreq_ex, stallreq_mem,
    output id_reg1_read, id_reg2_read,
    output id_reg1_addr, id_reg2_addr,
    output ex_mem_read, ex_wreg_write,
    output ex_wreg_addr,
    output flush_req, flush_target,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id,
    input  stallreq_ex, stallreq_mem,
    input  id_reg1_read, id_reg2_read,
    input  id_reg1_addr, id_reg2_addr,
    input  ex_mem_read, ex_wreg_write,
    input  ex_wreg_addr,
    input  flush_req, flush_target,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: stall vector with load-use detection, one-cycle
// exception flush sequencing and saturating stall/load-use counters.
module pipe_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int LU_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_ctrl_if.slave             pc,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [LU_CNT_W-1:0]    loaduse_count
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [STALL_CNT_W-1:0] SC_ONE = 1;
  localparam logic [LU_CNT_W-1:0]    LC_ONE = 1;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] tgt;
  logic [31:0] tgt_nxt;
  logic [5:0]  stall_v;
  logic        lu;
  logic        id_req;
  logic        hit1;
  logic        hit2;
  logic        lu_cnt_en;

  assign hit1 = pc.id_reg1_read &
                (pc.id_reg1_addr == pc.ex_wreg_addr);
  assign hit2 = pc.id_reg2_read &
                (pc.id_reg2_addr == pc.ex_wreg_addr);
  assign lu = pc.ex_mem_read & pc.ex_wreg_write &
              (pc.ex_wreg_addr != 5'd0) & (hit1 | hit2);
  assign id_req = pc.stallreq_id | lu;

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    stall_v   = 6'b000000;
    lu_cnt_en = 1'b0;
    case (state)
      RUN: begin
        if (pc.stallreq_mem)
          stall_v = 6'b011111;
        else if (pc.stallreq_ex)
          stall_v = 6'b001111;
        else if (id_req)
          stall_v = 6'b000111;
        else if (pc.stallreq_if)
          stall_v = 6'b000011;
        lu_cnt_en = lu & ~pc.stallreq_ex &
                    ~pc.stallreq_mem;
        // MEM holds flush_req stable while it stalls
        if (pc.flush_req && !pc.stallreq_mem) begin
          tgt_nxt   = pc.flush_target;
          state_nxt = FLUSH;
        end
      end
      FLUSH: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign pc.stall  = rst ? 6'b000000 : stall_v;
  assign pc.flush  = (state == FLUSH);
  assign pc.new_pc = pc.flush ? tgt : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      tgt   <= 32'd0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      loaduse_count <= '0;
    end else begin
      if ((pc.stall != 6'b0) && !(&stall_cycles))
        stall_cycles <= stall_cycles + SC_ONE;
      if (lu_cnt_en && !(&loaduse_count))
        loaduse_count <= loaduse_count + LC_ONE;
    end
  end

endmodule
